// File: rtl/fetch_sequencer_if.sv
// Fetch-stage bundle: execute-stage redirect, decode stall, instruction-memory
// handshake and the queue-head instruction presented to IF/ID.
interface fetch_sequencer_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              inp_pcsrc;
  logic [ADDR_W-1:0] inp_branchTarget;
  logic              inp_stall;
  logic              out_imem_req;
  logic [ADDR_W-1:0] out_imem_addr;
  logic              inp_imem_ack;
  logic [31:0]       inp_imem_data;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_instr_pc;
  logic              out_instr_valid;

  // Sequencer side
  modport master (
    input  inp_pcsrc, inp_branchTarget, inp_stall, inp_imem_ack, inp_imem_data,
    output out_imem_req, out_imem_addr, out_instr, out_instr_pc, out_instr_valid
  );

  // Memory / pipeline side
  modport slave (
    output inp_pcsrc, inp_branchTarget, inp_stall, inp_imem_ack, inp_imem_data,
    input  out_imem_req, out_imem_addr, out_instr, out_instr_pc, out_instr_valid
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch controller: one outstanding imem request, 2-entry instruction queue,
// branch redirect with flush and discard of the in-flight response.
module fetch_sequencer #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] PC_INC   = ADDR_W'(4)
) (
  input  logic              inp_clk,
  input  logic              inp_rst,
  fetch_sequencer_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  state_e            state_q;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] pc_q;
  logic              kill_q;
  logic [1:0]        count_q, count_d;
  logic [31:0]       h_instr_q, h_instr_d, t_instr_q, t_instr_d;
  logic [ADDR_W-1:0] h_pc_q, h_pc_d, t_pc_q, t_pc_d;

  logic              pop, push, to_tail, go_issue;
  logic [ADDR_W-1:0] src;

  // Queue bookkeeping; redirect overrides any coinciding push or pop.
  always_comb begin
    pop       = (count_q != 2'd0) && !bus.inp_stall;
    push      = (state_q == ISSUE) && bus.inp_imem_ack && !kill_q && !bus.inp_pcsrc;
    src       = bus.inp_pcsrc ? bus.inp_branchTarget : pc_q;
    to_tail   = (count_q - 2'(pop)) != 2'd0;
    count_d   = count_q;
    h_instr_d = h_instr_q;
    h_pc_d    = h_pc_q;
    t_instr_d = t_instr_q;
    t_pc_d    = t_pc_q;
    if (bus.inp_pcsrc) begin
      count_d = '0;
    end else begin
      count_d = count_q + 2'(push) - 2'(pop);
      if (pop) begin
        h_instr_d = t_instr_q;
        h_pc_d    = t_pc_q;
      end
      if (push && !to_tail) begin
        h_instr_d = bus.inp_imem_data;
        h_pc_d    = addr_q;
      end
      if (push && to_tail) begin
        t_instr_d = bus.inp_imem_data;
        t_pc_d    = addr_q;
      end
    end
  end

  // A new request goes out whenever the queue will still have room for its
  // response, or a redirect needs to be fetched.
  always_comb begin
    go_issue = 1'b0;
    case (state_q)
      IDLE:    go_issue = 1'b1;
      ISSUE:   go_issue = bus.inp_imem_ack && (count_d < 2'd2);
      WAIT:    go_issue = (count_d < 2'd2) || bus.inp_pcsrc;
      default: go_issue = 1'b0;
    endcase
  end

  always_ff @(posedge inp_clk) begin
    if (inp_rst) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      addr_q    <= RESET_PC;
      pc_q      <= RESET_PC;
      kill_q    <= 1'b0;
      count_q   <= '0;
      h_instr_q <= '0;
      h_pc_q    <= '0;
      t_instr_q <= '0;
      t_pc_q    <= '0;
    end else begin
      count_q   <= count_d;
      h_instr_q <= h_instr_d;
      h_pc_q    <= h_pc_d;
      t_instr_q <= t_instr_d;
      t_pc_q    <= t_pc_d;

      if (state_q == ISSUE) begin
        if (bus.inp_imem_ack) begin
          kill_q <= 1'b0;
        end else if (bus.inp_pcsrc) begin
          kill_q <= 1'b1;
        end
      end

      if (go_issue) begin
        state_q <= ISSUE;
        req_q   <= 1'b1;
        addr_q  <= src;
        pc_q    <= src + PC_INC;
      end else if (state_q == ISSUE && bus.inp_imem_ack) begin
        state_q <= WAIT;
        req_q   <= 1'b0;
      end else if (state_q == ISSUE && bus.inp_pcsrc) begin
        // Request address must stay put until the ack; remember the target.
        pc_q <= bus.inp_branchTarget;
      end else if (state_q != ISSUE && state_q != WAIT) begin
        state_q <= IDLE;
        req_q   <= 1'b0;
      end
    end
  end

  assign bus.out_imem_req    = req_q;
  assign bus.out_imem_addr   = addr_q;
  assign bus.out_instr       = h_instr_q;
  assign bus.out_instr_pc    = h_pc_q;
  assign bus.out_instr_valid = (count_q != 2'd0);

endmodule
